// File: rtl/router_reg_hold_if.sv
// router_reg_hold_if: byte/control bundle between the router FSM + source
// (master side) and the router_reg_hold packet register stage (slave side).
interface router_reg_hold_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  pkt_valid;
    logic                  fifo_full;
    logic                  detect_add;
    logic                  lfd_state;
    logic                  ld_state;
    logic                  laf_state;
    logic                  full_state;
    logic                  rst_int_reg;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_we;
    logic                  hold_empty;
    logic                  low_pkt_valid;
    logic                  parity_done;
    logic                  err;
    logic                  len_err;
    logic                  ovf_err;

    modport master (
        output pkt_valid, fifo_full, detect_add, lfd_state, ld_state,
               laf_state, full_state, rst_int_reg, data_in,
        input  dout, dout_we, hold_empty, low_pkt_valid, parity_done,
               err, len_err, ovf_err
    );

    modport slave (
        input  pkt_valid, fifo_full, detect_add, lfd_state, ld_state,
               laf_state, full_state, rst_int_reg, data_in,
        output dout, dout_we, hold_empty, low_pkt_valid, parity_done,
               err, len_err, ovf_err
    );
endinterface

// File: rtl/router_reg_hold.sv
// router_reg_hold: packet register stage of the 1x3 router.
// Captures the header, forwards payload bytes straight to the output FIFO or
// parks them in a small circular hold buffer while the FIFO is full, and
// checks XOR parity (and optionally payload length) against the packet.
// Optional feature: define ROUTER_REG_LEN_CHECK_EN to build the payload
// counter and len_err; otherwise len_err is tied low.
module router_reg_hold #(
    parameter int DATA_WIDTH = 8,
    parameter int HOLD_DEPTH = 2,
    parameter int CNT_WIDTH  = 6
) (
    input  logic             clock,
    input  logic             reset,
    router_reg_hold_if.slave bus
);
    localparam int PTR_WIDTH = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
    localparam int OCC_WIDTH = $clog2(HOLD_DEPTH + 1);
    localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(HOLD_DEPTH - 1);
    localparam logic [OCC_WIDTH-1:0] OCC_FULL = OCC_WIDTH'(HOLD_DEPTH);

    generate
        if (DATA_WIDTH < 3) begin : g_bad_data_width
            $error("router_reg_hold: DATA_WIDTH must be at least 3");
        end
        if (HOLD_DEPTH < 1) begin : g_bad_hold_depth
            $error("router_reg_hold: HOLD_DEPTH must be at least 1");
        end
        if (CNT_WIDTH < DATA_WIDTH - 2) begin : g_bad_cnt_width
            $error("router_reg_hold: CNT_WIDTH must be at least DATA_WIDTH-2");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] hdr_reg;
    logic [DATA_WIDTH-1:0] dout_reg;
    logic                  dout_we_reg;
    logic [DATA_WIDTH-1:0] iparity_reg;
    logic [DATA_WIDTH-1:0] iparity_next;
    logic [DATA_WIDTH-1:0] ppar_reg;
    logic                  par_seen_reg;
    logic                  parity_done_reg;
    logic                  low_pkt_valid_reg;
    logic                  err_reg;
    logic                  ovf_err_reg;
    logic                  hold_empty_reg;

    logic [DATA_WIDTH-1:0] hold_mem [HOLD_DEPTH];
    logic [PTR_WIDTH-1:0]  head_reg;
    logic [PTR_WIDTH-1:0]  head_next;
    logic [PTR_WIDTH-1:0]  tail_reg;
    logic [PTR_WIDTH-1:0]  tail_next;
    logic [OCC_WIDTH-1:0]  occ_reg;
    logic [OCC_WIDTH-1:0]  occ_next;

    logic accept;
    logic hold_has_data;
    logic direct;
    logic push_req;
    logic overflow;
    logic push;
    logic pop;
    logic par_byte;

    // Path selection. The header slot (lfd) owns dout, so a byte accepted in
    // the same cycle is routed through the hold buffer instead of being lost.
    assign accept        = bus.ld_state && !bus.full_state;
    assign hold_has_data = (occ_reg != '0);
    assign direct        = accept && !bus.lfd_state && !bus.fifo_full && !hold_has_data;
    assign push_req      = accept && !direct;
    assign overflow      = push_req && (occ_reg == OCC_FULL);
    assign push          = push_req && !overflow;
    assign pop           = bus.laf_state && !bus.lfd_state && hold_has_data && !bus.fifo_full;
    assign par_byte      = accept && !bus.pkt_valid;

    // Next head/tail/occupancy of the circular hold buffer.
    always_comb begin
        head_next = head_reg;
        tail_next = tail_reg;
        occ_next  = occ_reg;
        if (bus.detect_add) begin
            head_next = '0;
            tail_next = '0;
            occ_next  = '0;
        end else begin
            if (pop) begin
                head_next = (head_reg == PTR_LAST) ? '0 : head_reg + PTR_WIDTH'(1);
            end
            if (push) begin
                tail_next = (tail_reg == PTR_LAST) ? '0 : tail_reg + PTR_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   occ_next = occ_reg + OCC_WIDTH'(1);
                2'b01:   occ_next = occ_reg - OCC_WIDTH'(1);
                default: occ_next = occ_reg;
            endcase
        end
    end

    // Hold buffer storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clock) begin
        if (push) begin
            hold_mem[tail_reg] <= bus.data_in;
        end
    end

    // Hold buffer pointers, occupancy and the registered empty flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_reg       <= '0;
            tail_reg       <= '0;
            occ_reg        <= '0;
            hold_empty_reg <= 1'b1;
        end else begin
            head_reg       <= head_next;
            tail_reg       <= tail_next;
            occ_reg        <= occ_next;
            hold_empty_reg <= (occ_next == '0);
        end
    end

    // Output byte: header first, then direct bytes or replayed held bytes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout_reg    <= '0;
            dout_we_reg <= 1'b0;
        end else begin
            dout_we_reg <= 1'b0;
            if (bus.lfd_state) begin
                dout_reg    <= hdr_reg;
                dout_we_reg <= 1'b1;
            end else if (direct) begin
                dout_reg    <= bus.data_in;
                dout_we_reg <= 1'b1;
            end else if (pop) begin
                dout_reg    <= hold_mem[head_reg];
                dout_we_reg <= 1'b1;
            end
        end
    end

    // Running XOR of header and payload bytes for this cycle.
    always_comb begin
        iparity_next = iparity_reg;
        if (bus.lfd_state) begin
            iparity_next = iparity_next ^ hdr_reg;
        end
        if (accept && bus.pkt_valid) begin
            iparity_next = iparity_next ^ bus.data_in;
        end
    end

    // Header capture, parity tracking, parity-byte status and error flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hdr_reg           <= '0;
            iparity_reg       <= '0;
            ppar_reg          <= '0;
            par_seen_reg      <= 1'b0;
            parity_done_reg   <= 1'b0;
            low_pkt_valid_reg <= 1'b0;
            err_reg           <= 1'b0;
            ovf_err_reg       <= 1'b0;
        end else begin
            if (bus.detect_add && bus.pkt_valid) begin
                hdr_reg <= bus.data_in;
            end
            if (bus.detect_add) begin
                iparity_reg     <= '0;
                ppar_reg        <= '0;
                par_seen_reg    <= 1'b0;
                parity_done_reg <= 1'b0;
                ovf_err_reg     <= 1'b0;
            end else begin
                iparity_reg  <= iparity_next;
                par_seen_reg <= par_byte;
                if (par_seen_reg) begin
                    parity_done_reg <= 1'b1;
                end
                if (par_byte) begin
                    ppar_reg <= bus.data_in;
                end
                if (overflow) begin
                    ovf_err_reg <= 1'b1;
                end
            end
            // Setting wins over the FSM's clear when both land together.
            if (par_byte) begin
                low_pkt_valid_reg <= 1'b1;
            end else if (bus.rst_int_reg) begin
                low_pkt_valid_reg <= 1'b0;
            end
            err_reg <= parity_done_reg && (iparity_reg != ppar_reg);
        end
    end

`ifdef ROUTER_REG_LEN_CHECK_EN
    logic [CNT_WIDTH-1:0] pay_cnt_reg;
    logic [CNT_WIDTH-1:0] hdr_len;
    logic                 len_err_reg;

    assign hdr_len = CNT_WIDTH'(hdr_reg[DATA_WIDTH-1:2]);

    // Saturating payload byte counter and length compare once parity is in.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pay_cnt_reg <= '0;
            len_err_reg <= 1'b0;
        end else begin
            if (bus.detect_add) begin
                pay_cnt_reg <= '0;
            end else if (accept && bus.pkt_valid && (pay_cnt_reg != '1)) begin
                pay_cnt_reg <= pay_cnt_reg + CNT_WIDTH'(1);
            end
            len_err_reg <= parity_done_reg && (pay_cnt_reg != hdr_len);
        end
    end

    assign bus.len_err = len_err_reg;
`else
    assign bus.len_err = 1'b0;
`endif

    assign bus.dout          = dout_reg;
    assign bus.dout_we       = dout_we_reg;
    assign bus.hold_empty    = hold_empty_reg;
    assign bus.low_pkt_valid = low_pkt_valid_reg;
    assign bus.parity_done   = parity_done_reg;
    assign bus.err           = err_reg;
    assign bus.ovf_err       = ovf_err_reg;
endmodule

// File: tb/tb_router_reg_hold.sv
// tb_router_reg_hold: directed packet table, a reset-mid-packet sequence and
// random packets checked against a queue-based reference model.
module tb_router_reg_hold;
    localparam int DW = 8;
    localparam int HD = 2;
    localparam int CW = 6;
`ifdef ROUTER_REG_LEN_CHECK_EN
    localparam bit LEN_EN = 1'b1;
`else
    localparam bit LEN_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;

    router_reg_hold_if #(.DATA_WIDTH(DW)) bus ();

    router_reg_hold #(
        .DATA_WIDTH(DW),
        .HOLD_DEPTH(HD),
        .CNT_WIDTH (CW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state: output byte stream and hold queue.
    logic [7:0] m_hdr;
    logic [7:0] m_hold [$];
    logic       m_ovf;
    logic [7:0] m_dout;
    logic       m_we;

    typedef struct {
        logic [7:0]  hdr;
        int          npay;
        logic [7:0]  pay [16];
        logic [7:0]  par;
        logic [16:0] stall;
        bit          exp_err;
        bit          exp_len;
        bit          exp_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        bus.pkt_valid   = 1'b0;
        bus.fifo_full   = 1'b0;
        bus.detect_add  = 1'b0;
        bus.lfd_state   = 1'b0;
        bus.ld_state    = 1'b0;
        bus.laf_state   = 1'b0;
        bus.full_state  = 1'b0;
        bus.rst_int_reg = 1'b0;
        bus.data_in     = 8'h00;
    endtask

    task automatic model_reset();
        m_hold.delete();
        m_ovf  = 1'b0;
        m_dout = 8'h00;
        m_we   = 1'b0;
        m_hdr  = 8'h00;
    endtask

    // One clock: advance the model with the inputs present at the edge, then compare.
    task automatic step();
        int  sz;
        bit  acc;
        bit  dir;
        bit  pop;
        @(posedge clock);
        m_we = 1'b0;
        if (bus.detect_add) begin
            if (bus.pkt_valid) m_hdr = bus.data_in;
            m_hold.delete();
            m_ovf = 1'b0;
        end else begin
            sz  = m_hold.size();
            acc = bus.ld_state && !bus.full_state;
            dir = acc && !bus.lfd_state && !bus.fifo_full && (sz == 0);
            pop = bus.laf_state && !bus.lfd_state && (sz > 0) && !bus.fifo_full;
            if (bus.lfd_state) begin
                m_dout = m_hdr;
                m_we   = 1'b1;
            end else if (dir) begin
                m_dout = bus.data_in;
                m_we   = 1'b1;
            end else if (pop) begin
                m_dout = m_hold[0];
                m_we   = 1'b1;
            end
            if (pop) void'(m_hold.pop_front());
            if (acc && !dir) begin
                if (sz == HD) m_ovf = 1'b1;
                else m_hold.push_back(bus.data_in);
            end
        end
        #1;
        chk("dout_we", 32'(bus.dout_we), 32'(m_we));
        chk("dout", 32'(bus.dout), 32'(m_dout));
        chk("hold_empty", 32'(bus.hold_empty), 32'(m_hold.size() == 0));
        chk("ovf_err", 32'(bus.ovf_err), 32'(m_ovf));
    endtask

    // Drain the hold buffer in LAF; fifo_full randomly blocks when rnd is set.
    task automatic drain(input bit rnd);
        int guard;
        guard = 0;
        while (m_hold.size() != 0 && guard < 40) begin
            idle_in();
            bus.laf_state = 1'b1;
            bus.fifo_full = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            step();
            guard++;
        end
        chk("drain_hold_empty", 32'(bus.hold_empty), 32'(1));
    endtask

    task automatic run_packet(input vec_t v, input bit rnd, input bit int_with_par);
        bit st;
        idle_in();
        bus.detect_add = 1'b1;
        bus.pkt_valid  = 1'b1;
        bus.data_in    = v.hdr;
        step();
        idle_in();
        bus.lfd_state = 1'b1;
        step();
        chk("err_cleared", 32'(bus.err), 32'(0));
        chk("parity_done_cleared", 32'(bus.parity_done), 32'(0));
        for (int i = 0; i <= v.npay; i++) begin
            st = v.stall[i];
            if (m_hold.size() != 0 && (rnd ? ($urandom_range(0, 1) == 1) : !st)) drain(rnd);
            if (rnd && $urandom_range(0, 3) == 0) begin
                idle_in();
                bus.ld_state   = 1'b1;
                bus.full_state = 1'b1;
                bus.pkt_valid  = 1'b1;
                bus.fifo_full  = 1'($urandom_range(0, 1));
                bus.data_in    = 8'($urandom);
                step();
            end
            idle_in();
            bus.ld_state  = 1'b1;
            bus.fifo_full = st;
            bus.pkt_valid = (i != v.npay);
            bus.data_in   = (i == v.npay) ? v.par : v.pay[i];
            if (i == v.npay) bus.rst_int_reg = int_with_par;
            step();
        end
        chk("low_pkt_valid_set", 32'(bus.low_pkt_valid), 32'(1));
        drain(rnd);
        idle_in();
        repeat (3) step();
        chk("parity_done", 32'(bus.parity_done), 32'(1));
        chk("err", 32'(bus.err), 32'(v.exp_err));
        chk("len_err", 32'(bus.len_err), 32'(v.exp_len && LEN_EN));
        if (!rnd) chk("ovf_final", 32'(bus.ovf_err), 32'(v.exp_ovf));
        idle_in();
        bus.rst_int_reg = 1'b1;
        step();
        chk("low_pkt_valid_clr", 32'(bus.low_pkt_valid), 32'(0));
        $display("pkt hdr=%02h npay=%0d par=%02h err=%0b len_err=%0b ovf=%0b",
                 v.hdr, v.npay, v.par, bus.err, bus.len_err, bus.ovf_err);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t       tbl [6];
        vec_t       rv;
        logic [7:0] base [5];
        logic [7:0] x;
        int         len;
        int         r;

        base = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int k = 0; k < 6; k++) begin
            tbl[k].hdr     = 8'h15;
            tbl[k].npay    = 5;
            tbl[k].par     = 8'h04;
            tbl[k].stall   = '0;
            tbl[k].exp_err = 1'b0;
            tbl[k].exp_len = 1'b0;
            tbl[k].exp_ovf = 1'b0;
            for (int i = 0; i < 16; i++) begin
                tbl[k].pay[i] = 8'h00;
                if (i < 5) tbl[k].pay[i] = base[i];
            end
        end
        tbl[1].par     = 8'h05;             // bad parity
        tbl[1].exp_err = 1'b1;
        tbl[2].stall   = 17'b0_0110_0;      // 0x33, 0x44 stalled
        tbl[3].stall   = 17'b0_1110_0;      // 0x33..0x55 stalled, third dropped
        tbl[3].exp_ovf = 1'b1;
        tbl[4].npay    = 4;                 // short payload, parity right for 4 bytes
        tbl[4].par     = 8'h51;
        tbl[4].exp_len = 1'b1;
        tbl[5].hdr     = 8'h01;             // length 0, parity only
        tbl[5].npay    = 0;
        tbl[5].par     = 8'h01;

        reset = 1'b1;
        idle_in();
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_hold_empty", 32'(bus.hold_empty), 32'(1));
        chk("rst_dout_we", 32'(bus.dout_we), 32'(0));
        chk("rst_dout", 32'(bus.dout), 32'(0));
        chk("rst_parity_done", 32'(bus.parity_done), 32'(0));
        chk("rst_err", 32'(bus.err), 32'(0));
        chk("rst_len_err", 32'(bus.len_err), 32'(0));
        chk("rst_ovf", 32'(bus.ovf_err), 32'(0));
        chk("rst_lpv", 32'(bus.low_pkt_valid), 32'(0));
        reset = 1'b0;

        for (int k = 0; k < 6; k++) run_packet(tbl[k], 1'b0, k[0]);

        // Asynchronous reset while two bytes sit in the hold buffer.
        idle_in();
        bus.detect_add = 1'b1;
        bus.pkt_valid  = 1'b1;
        bus.data_in    = 8'h15;
        step();
        idle_in();
        bus.lfd_state = 1'b1;
        step();
        idle_in();
        bus.ld_state  = 1'b1;
        bus.pkt_valid = 1'b1;
        bus.data_in   = 8'h11;
        step();
        bus.fifo_full = 1'b1;
        bus.data_in   = 8'h22;
        step();
        bus.data_in = 8'h33;
        step();
        idle_in();
        chk("held_before_reset", 32'(bus.hold_empty), 32'(0));
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("async_hold_empty", 32'(bus.hold_empty), 32'(1));
        chk("async_dout", 32'(bus.dout), 32'(0));
        chk("async_dout_we", 32'(bus.dout_we), 32'(0));
        chk("async_ovf", 32'(bus.ovf_err), 32'(0));
        chk("async_parity_done", 32'(bus.parity_done), 32'(0));
        reset = 1'b0;
        bus.laf_state = 1'b1;
        repeat (3) step();
        $display("pkt reset-mid-packet sequence done");

        // Random packets checked against the model and packet arithmetic.
        for (int p = 0; p < 25; p++) begin
            len = $urandom_range(0, 15);
            r   = $urandom_range(0, 3);
            rv.npay = len;
            if (r == 0) rv.npay = len + 1;
            else if (r == 1 && len > 0) rv.npay = len - 1;
            rv.hdr   = {6'(len), 2'($urandom_range(0, 2))};
            rv.stall = '0;
            x        = rv.hdr;
            for (int i = 0; i < 16; i++) begin
                rv.pay[i] = 8'($urandom);
                if (i < rv.npay) x = x ^ rv.pay[i];
            end
            for (int i = 0; i < 17; i++) rv.stall[i] = ($urandom_range(0, 2) == 0);
            rv.par     = ($urandom_range(0, 1) == 1) ? x : 8'($urandom);
            rv.exp_err = (rv.par != x);
            rv.exp_len = (rv.npay != len);
            rv.exp_ovf = 1'b0;
            run_packet(rv, 1'b1, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/router_reg_hold.md
Name: router_reg_hold

Overview:
- Parametrised packet register stage for the 1x3 router. Sits between the router FSM and the per-port output FIFOs.
- Captures the header and buffers up to HOLD_DEPTH bytes that arrive while the target FIFO is full, then replays them in order.
- Accumulates XOR parity over header and payload, and checks it against the trailing parity byte.
- Also checks the received payload length against the header length field.

Parameters:
- DATA_WIDTH, 8: width of data_in/dout. Must be at least 3.
- HOLD_DEPTH, 2: entries in the full-state hold buffer. Must be at least 1.
- CNT_WIDTH, 6: width of the payload byte counter. Must be at least DATA_WIDTH-2.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- pkt_valid  in  1  source byte valid; low marks the parity byte
- fifo_full  in  1  selected output FIFO full
- detect_add  in  1  FSM in DECODE_ADDRESS
- lfd_state  in  1  FSM in LOAD_FIRST_DATA
- ld_state  in  1  FSM in LOAD_DATA
- laf_state  in  1  FSM in LOAD_AFTER_FULL
- full_state  in  1  FSM in FIFO_FULL_STATE
- rst_int_reg  in  1  FSM clears low_pkt_valid
- data_in  in  DATA_WIDTH  byte from source
- dout  out  DATA_WIDTH  byte to output FIFO
- dout_we  out  1  dout carries a new byte this cycle
- hold_empty  out  1  hold buffer empty (FSM leaves LAF on this)
- low_pkt_valid  out  1  parity byte has been received
- parity_done  out  1  parity byte accepted; compare is valid
- err  out  1  parity mismatch
- len_err  out  1  payload length mismatch
- ovf_err  out  1  hold buffer overflow, sticky per packet

Behaviour:
- Reset (async, active-high): every register and output goes to 0, except hold_empty, which goes to 1. The hold buffer is emptied.
- Header capture: on detect_add && pkt_valid, hdr <= data_in.
- detect_add also clears internal parity, packet parity, payload count, parity_done, ovf_err and the hold buffer.
- Accepted byte: a cycle with ld_state && !full_state. Every accepted byte enters exactly one path.
  - Direct path: fifo_full==0 and hold buffer empty. Then dout <= data_in and dout_we <= 1.
  - Hold path: otherwise the byte is pushed into the hold buffer (circular, head/tail pointers plus count).
  - Push while count==HOLD_DEPTH: the byte is dropped and ovf_err <= 1. Parity and count still include the byte.
- lfd_state: dout <= hdr and dout_we <= 1. This takes priority over all other dout sources.
- laf_state with count>0 and fifo_full==0: pop the head entry. dout <= head entry, dout_we <= 1, one byte per cycle, in FIFO order.
- Simultaneous push and pop in one cycle: both happen and count is unchanged. The popped entry is never the entry being pushed.
- dout holds its value when no source is active. dout_we is 0 in every other cycle.
- hold_empty: registered, equals (count==0).
- Internal parity:
  - In lfd_state: iparity ^= hdr.
  - On an accepted byte with pkt_valid==1: iparity ^= data_in, and payload count increments, saturating at all-ones.
- Parity byte: an accepted byte with pkt_valid==0.
  - ppar <= data_in.
  - low_pkt_valid <= 1. low_pkt_valid clears on rst_int_reg; if both occur in the same cycle, the set wins.
  - parity_done <= 1 in the next cycle, and stays high until detect_add.
- err: registered each cycle as parity_done && (iparity != ppar). It is level, not sticky.
- len_err: registered each cycle as parity_done && (count != hdr[DATA_WIDTH-1:2]). It is level, not sticky.
- Header length 0: a packet carrying only a parity byte is legal; count 0 matches.
- Reset mid-packet: all state is lost immediately. Any bytes in the hold buffer are discarded without being emitted.
- Latency: data_in to dout is 1 cycle on the direct path. The hold path drains at 1 byte per cycle once LAF is active and fifo_full is low.

Optional Feature:
- Macro ROUTER_REG_LEN_CHECK_EN.
- Defined: the payload counter and len_err are implemented as described above.
- Undefined: no counter logic exists and len_err is tied to 0. All other behaviour is identical.

Test Plan:
- Basic packet, no stall:
  - Stimulus: header 0x15 (length 5, addr 1), payload 0x11 0x22 0x33 0x44 0x55, parity 0x04.
  - Response: dout sequence 0x15, 0x11..0x55, 0x04. parity_done=1, err=0, len_err=0.
- Bad parity: same packet with parity byte 0x05.
  - Response: err=1 the cycle after parity_done rises; err returns to 0 on the next detect_add.
- Stall: fifo_full asserted during payload bytes 0x33 and 0x44.
  - Response: both bytes held, hold_empty=0. In laf with fifo_full low, dout=0x33 then 0x44 on consecutive dout_we cycles, then hold_empty=1.
- Overflow with HOLD_DEPTH=2: three bytes pushed while fifo_full=1.
  - Response: ovf_err=1, third byte dropped, parity still computed over all five payload bytes.
- Length mismatch: header 0x15 followed by only 4 payload bytes and the correct parity for those bytes.
  - Response: err=0, len_err=1. With ROUTER_REG_LEN_CHECK_EN undefined, len_err=0.
- Asynchronous reset mid-packet: reset pulsed while 2 bytes are held.
  - Response: outputs go to reset values immediately, without waiting for a clock edge. hold_empty=1, and no held bytes are emitted afterwards.
